fetch_sequencer: RTL and testbench

Instruction fetch/phase sequencer that drives the processor's instruction decoder. It owns the program counter, fetch register, phase flip-flop and C/Z flag register, and presents the decoder's 7-bit input word {instr, C, Z, phase}. It accepts the decoder's PC-control outputs back and adds a run/halt/single-step controller so the core can be stepped one instruction at a time on the board.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_sequencer_run_ctrl.sv | 72 +++++++
 rtl/fetch_sequencer.sv | 79 +++++++
 tb/tb_fetch_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/phase sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  // Bit positions inside the decoder input word
  localparam int INSTR_MSB = 6;
  localparam int INSTR_LSB = 3;
  localparam int C_BIT     = 2;
  localparam int Z_BIT     = 1;
  localparam int PH_BIT    = 0;

  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_EXEC  = 1'b1;

endpackage

// File: rtl/fetch_sequencer_run_ctrl.sv
// Run/halt/single-step controller. Produces the advance strobe for the
// datapath and only ever leaves RUN/STEP on an execute edge, so the core
// always stops on an instruction boundary (phase back at fetch).
//
// state  | meaning
// HALTED | datapath frozen, waiting for run or step_req
// RUN    | free-running; halt requests deferred to the next execute edge
// STEP   | one fetch + one execute, then back to HALTED
module run_ctrl
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic halt_req,
  input  logic step_req,
  input  logic phase,
  output logic adv,
  output logic running
);

  state_t state;
  logic   halt_pending;
  logic   stop_now;

  // A stop request seen in this cycle or remembered from the fetch cycle
  assign stop_now = halt_pending | halt_req | ~run;
  assign adv      = (state == RUN) || (state == STEP);

  // Controller FSM with registered running flag and deferred-halt memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HALTED;
      running      <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      case (state)
        HALTED: begin
          halt_pending <= 1'b0;
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step_req) begin
            state   <= STEP;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (phase == PHASE_EXEC && stop_now) begin
            state        <= HALTED;
            running      <= 1'b0;
            halt_pending <= 1'b0;
          end else if (halt_req || !run) begin
            halt_pending <= 1'b1;
          end
        end
        STEP: begin
          if (phase == PHASE_EXEC) begin
            state   <= HALTED;
            running <= 1'b0;
          end
        end
        default: begin
          state        <= HALTED;
          running      <= 1'b0;
          halt_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/phase sequencer: owns pc, fetch register, phase and
// flags, and presents the registered decoder input word.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W = 12,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            halt_req,
  input  logic            step_req,
  input  logic [DW-1:0]   prog_byte,
  input  logic            inc_pc,
  input  logic            load_pc,
  input  logic [PC_W-1:0] load_addr,
  input  logic            flags_we,
  input  logic            c_in,
  input  logic            z_in,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            phase,
  output logic            c_flag,
  output logic            z_flag,
  output logic [6:0]      dec_in,
  output logic            running
);

  logic adv;

  run_ctrl u_run_ctrl (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .halt_req (halt_req),
    .step_req (step_req),
    .phase    (phase),
    .adv      (adv),
    .running  (running)
  );

  // Datapath registers move only on advance cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      instr  <= '0;
      oprnd  <= '0;
      phase  <= PHASE_FETCH;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (adv) begin
      phase <= ~phase;
      if (phase == PHASE_FETCH) begin
        instr <= prog_byte[DW-1:DW-4];
        oprnd <= prog_byte[3:0];
      end
      if (load_pc)
        pc <= load_addr;
      else if (inc_pc)
        pc <= pc + 1'b1;
      if (flags_we) begin
        c_flag <= c_in;
        z_flag <= z_in;
      end
    end
  end

  // Decoder word is wiring only; every bit comes straight from a register
  always_comb begin
    dec_in                      = '0;
    dec_in[INSTR_MSB:INSTR_LSB] = instr;
    dec_in[C_BIT]               = c_flag;
    dec_in[Z_BIT]               = z_flag;
    dec_in[PH_BIT]              = phase;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, halt_req, step_req;
  logic [7:0]  prog_byte;
  logic        inc_pc, load_pc;
  logic [11:0] load_addr;
  logic        flags_we, c_in, z_in;
  logic [11:0] pc;
  logic [3:0]  instr, oprnd;
  logic        phase, c_flag, z_flag;
  logic [6:0]  dec_in;
  logic        running;

  int n_pass = 0;
  int n_total = 0;

  fetch_sequencer #(.PC_W(12), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .prog_byte (prog_byte),
    .inc_pc    (inc_pc),
    .load_pc   (load_pc),
    .load_addr (load_addr),
    .flags_we  (flags_we),
    .c_in      (c_in),
    .z_in      (z_in),
    .pc        (pc),
    .instr     (instr),
    .oprnd     (oprnd),
    .phase     (phase),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .dec_in    (dec_in),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 0; halt_req = 0; step_req = 0; prog_byte = 8'h00;
    inc_pc = 0; load_pc = 0; load_addr = '0; flags_we = 0; c_in = 0; z_in = 0;
    repeat (2) tick();
    n_total++; if (pc !== 12'h000) $display("FAIL reset_pc got %h want 000", pc); else n_pass++;
    n_total++; if (dec_in !== 7'b0000000) $display("FAIL reset_dec_in got %b want 0000000", dec_in); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (running !== 1'b0) $display("FAIL idle_halted got %b want 0", running); else n_pass++;
  endtask

  task automatic test_fetch();
    run = 1; prog_byte = 8'h5A; inc_pc = 1;
    tick();  // HALTED -> RUN, no advance yet
    n_total++; if (running !== 1'b1) $display("FAIL run_start_running got %b want 1", running); else n_pass++;
    n_total++; if (pc !== 12'h000) $display("FAIL run_start_pc got %h want 000", pc); else n_pass++;
    tick();  // fetch edge
    n_total++; if (instr !== 4'h5) $display("FAIL fetch_instr got %h want 5", instr); else n_pass++;
    n_total++; if (oprnd !== 4'hA) $display("FAIL fetch_oprnd got %h want a", oprnd); else n_pass++;
    n_total++; if (dec_in !== 7'b0101001) $display("FAIL fetch_dec_in got %b want 0101001", dec_in); else n_pass++;
    n_total++; if (pc !== 12'h001) $display("FAIL fetch_pc got %h want 001", pc); else n_pass++;
    tick();  // execute edge
    n_total++; if (phase !== 1'b0) $display("FAIL exec_phase got %b want 0", phase); else n_pass++;
    n_total++; if (pc !== 12'h002) $display("FAIL exec_pc got %h want 002", pc); else n_pass++;
  endtask

  task automatic test_pc();
    load_pc = 1; load_addr = 12'hFFF; inc_pc = 0;
    tick();
    n_total++; if (pc !== 12'hFFF) $display("FAIL pc_load got %h want fff", pc); else n_pass++;
    load_pc = 0; inc_pc = 1;
    tick();
    n_total++; if (pc !== 12'h000) $display("FAIL pc_wrap got %h want 000", pc); else n_pass++;
    load_pc = 1; load_addr = 12'h040; inc_pc = 1;
    tick();
    n_total++; if (pc !== 12'h040) $display("FAIL pc_load_priority got %h want 040", pc); else n_pass++;
    load_pc = 0; inc_pc = 0;
    tick();
    n_total++; if (pc !== 12'h040) $display("FAIL pc_hold got %h want 040", pc); else n_pass++;
    n_total++; if (phase !== 1'b0) $display("FAIL pc_phase got %b want 0", phase); else n_pass++;
  endtask

  task automatic test_flags();
    tick();  // fetch edge, now in execute cycle
    flags_we = 1; c_in = 1; z_in = 0;
    tick();
    n_total++; if (dec_in[2:1] !== 2'b10) $display("FAIL flags_write got %b want 10", dec_in[2:1]); else n_pass++;
    flags_we = 0; c_in = 0; z_in = 1;
    repeat (2) tick();
    n_total++; if (dec_in[2:1] !== 2'b10) $display("FAIL flags_hold got %b want 10", dec_in[2:1]); else n_pass++;
  endtask

  task automatic test_halt_exec();
    tick();  // fetch edge, execute cycle follows
    halt_req = 1;
    tick();
    halt_req = 0;
    n_total++; if (running !== 1'b0) $display("FAIL halt_exec_running got %b want 0", running); else n_pass++;
    n_total++; if (phase !== 1'b0) $display("FAIL halt_exec_phase got %b want 0", phase); else n_pass++;
    run = 0;
    tick();
    n_total++; if (running !== 1'b0) $display("FAIL halt_exec_stays got %b want 0", running); else n_pass++;
  endtask

  task automatic test_halt_fetch();
    run = 1;
    tick();  // enter RUN, fetch cycle follows
    halt_req = 1;
    tick();
    halt_req = 0;
    n_total++; if (running !== 1'b1) $display("FAIL halt_fetch_mid got %b want 1", running); else n_pass++;
    n_total++; if (phase !== 1'b1) $display("FAIL halt_fetch_mid_phase got %b want 1", phase); else n_pass++;
    tick();
    n_total++; if (running !== 1'b0) $display("FAIL halt_fetch_running got %b want 0", running); else n_pass++;
    n_total++; if (phase !== 1'b0) $display("FAIL halt_fetch_phase got %b want 0", phase); else n_pass++;
    run = 0;
    tick();
  endtask

  task automatic test_step();
    inc_pc = 1; prog_byte = 8'h3C;
    step_req = 1;
    tick();
    step_req = 0;
    n_total++; if (running !== 1'b1) $display("FAIL step_enter got %b want 1", running); else n_pass++;
    n_total++; if (pc !== 12'h040) $display("FAIL step_enter_pc got %h want 040", pc); else n_pass++;
    tick();
    step_req = 1;  // must be ignored while stepping
    n_total++; if (pc !== 12'h041) $display("FAIL step_fetch_pc got %h want 041", pc); else n_pass++;
    tick();
    step_req = 0;
    n_total++; if (running !== 1'b0) $display("FAIL step_done got %b want 0", running); else n_pass++;
    n_total++; if (phase !== 1'b0) $display("FAIL step_phase got %b want 0", phase); else n_pass++;
    n_total++; if (instr !== 4'h3) $display("FAIL step_instr got %h want 3", instr); else n_pass++;
    repeat (2) tick();
    n_total++; if (pc !== 12'h042) $display("FAIL step_pc_final got %h want 042", pc); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL step_second_ignored got %b want 0", running); else n_pass++;
    inc_pc = 0;
  endtask

  task automatic test_run_wins();
    run = 1; step_req = 1;
    tick();
    step_req = 0;
    repeat (2) tick();  // fetch + execute; STEP would have halted here
    n_total++; if (running !== 1'b1) $display("FAIL run_over_step got %b want 1", running); else n_pass++;
    run = 0;
    repeat (2) tick();
    n_total++; if (running !== 1'b0) $display("FAIL run_drop_halt got %b want 0", running); else n_pass++;
    n_total++; if (phase !== 1'b0) $display("FAIL run_drop_phase got %b want 0", phase); else n_pass++;
  endtask

  task automatic test_reset_async();
    run = 1; flags_we = 1; c_in = 1; z_in = 1;
    tick();  // enter RUN
    load_pc = 1; load_addr = 12'h123;
    tick();  // fetch edge: pc=123, phase=1
    load_pc = 0; flags_we = 0;
    n_total++; if (pc !== 12'h123) $display("FAIL pre_reset_pc got %h want 123", pc); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (pc !== 12'h000) $display("FAIL async_reset_pc got %h want 000", pc); else n_pass++;
    n_total++; if (dec_in !== 7'b0000000) $display("FAIL async_reset_dec_in got %b want 0000000", dec_in); else n_pass++;
    n_total++; if (oprnd !== 4'h0) $display("FAIL async_reset_oprnd got %h want 0", oprnd); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL async_reset_running got %b want 0", running); else n_pass++;
    run = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_pc();
    test_flags();
    test_halt_exec();
    test_halt_fetch();
    test_step();
    test_run_wins();
    test_reset_async();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
